// File: rtl/tap_driver_if.sv
// Command/response channel between a test sequencer and the JTAG TAP driver.
interface tap_driver_if #(
  parameter int unsigned MAXLEN = 32
);
  localparam int unsigned LEN_W = $clog2(MAXLEN);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [LEN_W-1:0]  cmd_len;
  logic [MAXLEN-1:0] cmd_data;
  logic              rsp_valid;
  logic [MAXLEN-1:0] rsp_data;

  // Sequencer side issues commands and consumes responses.
  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  // Driver side accepts commands and produces responses.
  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/tap_driver.sv
// JTAG TAP master: lock-step model of the target controller that turns
// reset / IR scan / DR scan / idle commands into TMS/TDI sequences and
// returns the TDO bits captured during the shift states.
module tap_driver #(
  parameter int unsigned MAXLEN = 32
) (
  input  logic         TCK,
  input  logic         TRST_b,
  tap_driver_if.slave  bus,
  output logic         tms,
  output logic         tdi,
  input  logic         tdo_i
);

  localparam int unsigned LEN_W = $clog2(MAXLEN);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    OP_RST  = 2'b00,
    OP_IR   = 2'b01,
    OP_DR   = 2'b10,
    OP_IDLE = 2'b11
  } op_e;

  tap_state_e        state;
  tap_state_e        state_nxt;
  logic              busy;
  op_e               op;
  logic [LEN_W-1:0]  len;
  logic [MAXLEN-1:0] data;
  logic [MAXLEN-1:0] rdata;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  idle_cnt;
  logic [2:0]        rst_cnt;
  logic              shifting;
  logic              done;

  // TMS/TDI come only from registered state so cmd_* never reach the pins.
  always_comb begin
    tms      = 1'b0;
    shifting = (state == SHIFT_DR) || (state == SHIFT_IR);
    if (busy && (op == OP_RST)) begin
      // five ones walk any state into TLR, then a zero lands in RTI
      tms = (rst_cnt != 3'd5);
    end else begin
      case (state)
        RTI:                 tms = busy && (op != OP_IDLE);
        SEL_DR:              tms = busy && (op == OP_IR);
        SHIFT_DR, SHIFT_IR:  tms = (cnt == len);
        EXIT1_DR, EXIT1_IR:  tms = 1'b1;
        default:             tms = 1'b0;
      endcase
    end
    tdi = shifting ? data[cnt] : 1'b0;
  end

  // Target TAP transition function for the states this driver visits.
  always_comb begin
    state_nxt = TLR;
    case (state)
      TLR:      state_nxt = tms ? TLR      : RTI;
      RTI:      state_nxt = tms ? SEL_DR   : RTI;
      SEL_DR:   state_nxt = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nxt = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_nxt = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_nxt = UPD_DR;
      UPD_DR:   state_nxt = tms ? SEL_DR   : RTI;
      SEL_IR:   state_nxt = tms ? TLR      : CAP_IR;
      CAP_IR:   state_nxt = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_nxt = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_nxt = UPD_IR;
      UPD_IR:   state_nxt = tms ? SEL_DR   : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  // Completion: entering RTI from an update/reset, or the last idle edge.
  always_comb begin
    done = 1'b0;
    if (busy) begin
      case (op)
        OP_RST:  done = (rst_cnt == 3'd5);
        OP_IDLE: done = (state == RTI) && (idle_cnt == len);
        default: done = (state == UPD_DR) || (state == UPD_IR);
      endcase
    end
  end

  // Controller state, command latch, capture register and response.
  always_ff @(posedge TCK or negedge TRST_b) begin
    if (!TRST_b) begin
      state         <= TLR;
      busy          <= 1'b0;
      op            <= OP_RST;
      len           <= '0;
      data          <= '0;
      rdata         <= '0;
      cnt           <= '0;
      idle_cnt      <= '0;
      rst_cnt       <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      state         <= state_nxt;
      bus.rsp_valid <= 1'b0;
      if (bus.cmd_ready && bus.cmd_valid) begin
        busy          <= 1'b1;
        bus.cmd_ready <= 1'b0;
        op            <= op_e'(bus.cmd_op);
        len           <= bus.cmd_len;
        data          <= bus.cmd_data;
        rdata         <= '0;
        cnt           <= '0;
        idle_cnt      <= '0;
        rst_cnt       <= '0;
      end else if (busy) begin
        if (shifting) begin
          rdata[cnt] <= tdo_i;
          if (cnt != len) cnt <= LEN_W'(cnt + 1'b1);
        end
        if (op == OP_RST)  rst_cnt  <= 3'(rst_cnt + 3'd1);
        if (op == OP_IDLE) idle_cnt <= LEN_W'(idle_cnt + 1'b1);
        if (done) begin
          busy          <= 1'b0;
          bus.cmd_ready <= 1'b1;
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= ((op == OP_IR) || (op == OP_DR)) ? rdata : '0;
        end
      end else if (state_nxt == RTI) begin
        // arriving in RTI after TAP reset makes the driver available
        bus.cmd_ready <= 1'b1;
      end
    end
  end

endmodule
